// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - opcodes, state/class enums and select encodings for the sequencer
package multicycle_sequencer_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  // CLS_NONE doubles as the reset value and the "unrecognised opcode" marker
  typedef enum logic [3:0] {
    CLS_NONE     = 4'd0,
    CLS_OP       = 4'd1,
    CLS_OP_IMM   = 4'd2,
    CLS_LUI      = 4'd3,
    CLS_AUIPC    = 4'd4,
    CLS_LOAD     = 4'd5,
    CLS_STORE    = 4'd6,
    CLS_BRANCH   = 4'd7,
    CLS_JAL      = 4'd8,
    CLS_JALR     = 4'd9,
    CLS_MISC_MEM = 4'd10,
    CLS_SYSTEM   = 4'd11
  } class_t;

  localparam logic [1:0] ALU_A_RS1    = 2'd0;
  localparam logic [1:0] ALU_A_PC     = 2'd1;
  localparam logic [1:0] ALU_A_ZERO   = 2'd2;
  localparam logic       ALU_B_RS2    = 1'b0;
  localparam logic       ALU_B_IMM    = 1'b1;
  localparam logic       PC_SRC_PLUS4 = 1'b0;
  localparam logic       PC_SRC_ALU   = 1'b1;
  localparam logic [1:0] WB_ALU       = 2'd0;
  localparam logic [1:0] WB_LOAD      = 2'd1;
  localparam logic [1:0] WB_PC4       = 2'd2;

  function automatic class_t decode_class(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:       decode_class = CLS_OP;
      OPC_OP_IMM:   decode_class = CLS_OP_IMM;
      OPC_LUI:      decode_class = CLS_LUI;
      OPC_AUIPC:    decode_class = CLS_AUIPC;
      OPC_LOAD:     decode_class = CLS_LOAD;
      OPC_STORE:    decode_class = CLS_STORE;
      OPC_BRANCH:   decode_class = CLS_BRANCH;
      OPC_JAL:      decode_class = CLS_JAL;
      OPC_JALR:     decode_class = CLS_JALR;
      OPC_MISC_MEM: decode_class = CLS_MISC_MEM;
      OPC_SYSTEM:   decode_class = CLS_SYSTEM;
      default:      decode_class = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - bus handshake and datapath control bundle of the sequencer
interface multicycle_sequencer_if;

  logic [6:0] inst_opcode;
  logic       branch_taken;
  logic       inst_ready;
  logic       data_ready;
  logic       inst_read_enable;
  logic       inst_reg_write;
  logic       data_read_enable;
  logic       data_write_enable;
  logic [1:0] alu_a_select;
  logic       alu_b_select;
  logic       pc_write_enable;
  logic       pc_source;
  logic       regfile_write_enable;
  logic [1:0] writeback_select;
  logic       halted;
  logic       illegal_inst;
  logic       bus_error;

  modport slave (
    input  inst_opcode, branch_taken, inst_ready, data_ready,
    output inst_read_enable, inst_reg_write, data_read_enable, data_write_enable,
    output alu_a_select, alu_b_select, pc_write_enable, pc_source,
    output regfile_write_enable, writeback_select, halted, illegal_inst, bus_error
  );

  modport master (
    output inst_opcode, branch_taken, inst_ready, data_ready,
    input  inst_read_enable, inst_reg_write, data_read_enable, data_write_enable,
    input  alu_a_select, alu_b_select, pc_write_enable, pc_source,
    input  regfile_write_enable, writeback_select, halted, illegal_inst, bus_error
  );

endinterface

// File: rtl/multicycle_sequencer_bus_wait_counter.sv
// rtl/multicycle_sequencer_bus_wait_counter.sv - consecutive bus-wait cycle counter with limit flag
module bus_wait_counter #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic limit_reached
);

  localparam int              CW   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0]   LAST = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] count_q;

  // Saturates at the limit; the sequencer leaves the waiting state on that cycle anyway
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (count && (count_q != LAST))
      count_q <= count_q + CW'(1);
  end

  assign limit_reached = (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle fetch/decode/execute/memory/writeback control sequencer
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_sequencer_if.slave bus
);

  state_t state;
  class_t inst_class;
  logic   halted_q;
  logic   illegal_q;
  logic   bus_error_q;
  logic   waiting;
  logic   wait_clear;
  logic   wait_limit;

  assign waiting    = ((state == ST_FETCH)  && !bus.inst_ready) ||
                      ((state == ST_MEMORY) && !bus.data_ready);
  assign wait_clear = !waiting;

  bus_wait_counter #(.WAIT_LIMIT(WAIT_LIMIT)) u_bus_wait_counter (
    .clock         (clock),
    .reset         (reset),
    .clear         (wait_clear),
    .count         (waiting),
    .limit_reached (wait_limit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      inst_class  <= CLS_NONE;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          // ready wins over a limit hit in the same cycle
          if (bus.inst_ready) begin
            state <= ST_DECODE;
          end else if (wait_limit) begin
            state       <= ST_HALT;
            bus_error_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          inst_class <= decode_class(bus.inst_opcode);
          if (decode_class(bus.inst_opcode) == CLS_NONE) begin
            state     <= ST_HALT;
            illegal_q <= 1'b1;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (inst_class)
            CLS_LOAD, CLS_STORE:       state <= ST_MEMORY;
            CLS_BRANCH, CLS_MISC_MEM:  state <= ST_FETCH;
            CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR:
                                       state <= ST_WRITEBACK;
            CLS_SYSTEM: begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end
            default: begin
              state     <= ST_HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        ST_MEMORY: begin
          if (bus.data_ready) begin
            state <= (inst_class == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
          end else if (wait_limit) begin
            state       <= ST_HALT;
            bus_error_q <= 1'b1;
          end
        end
        ST_WRITEBACK: state <= ST_FETCH;
        default:      state <= ST_HALT;
      endcase
    end
  end

  // Controls decode from state and class; reset forces every control low immediately
  always_comb begin
    bus.inst_read_enable     = 1'b0;
    bus.inst_reg_write       = 1'b0;
    bus.data_read_enable     = 1'b0;
    bus.data_write_enable    = 1'b0;
    bus.alu_a_select         = ALU_A_RS1;
    bus.alu_b_select         = ALU_B_RS2;
    bus.pc_write_enable      = 1'b0;
    bus.pc_source            = PC_SRC_PLUS4;
    bus.regfile_write_enable = 1'b0;
    bus.writeback_select     = WB_ALU;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          bus.inst_read_enable = 1'b1;
          bus.inst_reg_write   = bus.inst_ready;
        end
        ST_EXECUTE: begin
          case (inst_class)
            CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_JALR: begin
              bus.alu_b_select = ALU_B_IMM;
            end
            CLS_AUIPC, CLS_JAL: begin
              bus.alu_a_select = ALU_A_PC;
              bus.alu_b_select = ALU_B_IMM;
            end
            CLS_BRANCH: begin
              bus.alu_a_select    = ALU_A_PC;
              bus.alu_b_select    = ALU_B_IMM;
              bus.pc_write_enable = 1'b1;
              bus.pc_source       = bus.branch_taken;
            end
            CLS_LUI: begin
              bus.alu_a_select = ALU_A_ZERO;
              bus.alu_b_select = ALU_B_IMM;
            end
            CLS_MISC_MEM: bus.pc_write_enable = 1'b1;
            default: ;
          endcase
        end
        ST_MEMORY: begin
          if (inst_class == CLS_LOAD) begin
            bus.data_read_enable = 1'b1;
          end else begin
            bus.data_write_enable = 1'b1;
            bus.pc_write_enable   = bus.data_ready;
          end
        end
        ST_WRITEBACK: begin
          bus.regfile_write_enable = 1'b1;
          bus.pc_write_enable      = 1'b1;
          if (inst_class == CLS_LOAD) begin
            bus.writeback_select = WB_LOAD;
          end else if ((inst_class == CLS_JAL) || (inst_class == CLS_JALR)) begin
            bus.writeback_select = WB_PC4;
            bus.pc_source        = PC_SRC_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.halted       = halted_q;
  assign bus.illegal_inst = illegal_q;
  assign bus.bus_error    = bus_error_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic clock;
  logic reset;
  int   passed;
  int   total;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.WAIT_LIMIT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view: ire irw dre dwe a[1:0] b pcwe pcs rfwe wbs[1:0] halted illegal bus_error 0
  function automatic logic [15:0] v(input bit ire, input bit irw, input bit dre, input bit dwe,
                                    input bit [1:0] a, input bit b, input bit pcwe, input bit pcs,
                                    input bit rfwe, input bit [1:0] wbs,
                                    input bit h, input bit ill, input bit be);
    return {ire, irw, dre, dwe, a, b, pcwe, pcs, rfwe, wbs, h, ill, be, 1'b0};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.inst_read_enable, bus.inst_reg_write, bus.data_read_enable, bus.data_write_enable,
            bus.alu_a_select, bus.alu_b_select, bus.pc_write_enable, bus.pc_source,
            bus.regfile_write_enable, bus.writeback_select,
            bus.halted, bus.illegal_inst, bus.bus_error, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic ir, input logic dr, input logic bt,
                      input logic [15:0] exp);
    @(negedge clock);
    bus.inst_ready   = ir;
    bus.data_ready   = dr;
    bus.branch_taken = bt;
    #1;
    check(tag, obs(), exp);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset          = 1'b1;
    bus.inst_ready = 1'b0;
    bus.data_ready = 1'b0;
    #1;
    check(tag, obs(), 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check({tag, "_first_fetch"}, obs(), v(1,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  logic [15:0] f0, f1, z;

  initial begin
    passed = 0;
    total  = 0;
    f0 = v(1,0,0,0, 0,0,0,0,0,0, 0,0,0);
    f1 = v(1,1,0,0, 0,0,0,0,0,0, 0,0,0);
    z  = 16'h0000;

    reset            = 1'b1;
    bus.inst_opcode  = 7'b0010011;
    bus.branch_taken = 1'b0;
    bus.inst_ready   = 1'b0;
    bus.data_ready   = 1'b0;
    #1;
    check("reset_held", obs(), z);
    @(negedge clock);
    #1;
    check("reset_held2", obs(), z);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("first_fetch", obs(), f0);

    // ADDI x1,x0,5
    bus.inst_opcode = 7'b0010011;
    step("addi_f", 1, 0, 0, f1);
    step("addi_d", 0, 0, 0, z);
    step("addi_e", 0, 0, 0, v(0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    step("addi_wb", 0, 0, 0, v(0,0,0,0, 0,0,1,0,1,0, 0,0,0));

    // LW with data_ready three cycles late
    bus.inst_opcode = 7'b0000011;
    step("lw_f", 1, 0, 0, f1);
    step("lw_d", 0, 0, 0, z);
    step("lw_e", 0, 0, 0, v(0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) step("lw_m_wait", 0, 0, 0, v(0,0,1,0, 0,0,0,0,0,0, 0,0,0));
    step("lw_m_done", 0, 1, 0, v(0,0,1,0, 0,0,0,0,0,0, 0,0,0));
    step("lw_wb", 0, 0, 0, v(0,0,0,0, 0,0,1,0,1,1, 0,0,0));

    // BEQ taken then not taken
    bus.inst_opcode = 7'b1100011;
    step("beq1_f", 1, 0, 0, f1);
    step("beq1_d", 0, 0, 0, z);
    step("beq1_e", 0, 0, 1, v(0,0,0,0, 1,1,1,1,0,0, 0,0,0));
    step("beq0_f", 1, 0, 0, f1);
    step("beq0_d", 0, 0, 0, z);
    step("beq0_e", 0, 0, 0, v(0,0,0,0, 1,1,1,0,0,0, 0,0,0));

    // SW zero-wait
    bus.inst_opcode = 7'b0100011;
    step("sw_f", 1, 0, 0, f1);
    step("sw_d", 0, 0, 0, z);
    step("sw_e", 0, 0, 0, v(0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    step("sw_m", 0, 1, 0, v(0,0,0,1, 0,0,1,0,0,0, 0,0,0));

    // JAL
    bus.inst_opcode = 7'b1101111;
    step("jal_f", 1, 0, 0, f1);
    step("jal_d", 0, 0, 0, z);
    step("jal_e", 0, 0, 0, v(0,0,0,0, 1,1,0,0,0,0, 0,0,0));
    step("jal_wb", 0, 0, 0, v(0,0,0,0, 0,0,1,1,1,2, 0,0,0));

    // LUI
    bus.inst_opcode = 7'b0110111;
    step("lui_f", 1, 0, 0, f1);
    step("lui_d", 0, 0, 0, z);
    step("lui_e", 0, 0, 0, v(0,0,0,0, 2,1,0,0,0,0, 0,0,0));
    step("lui_wb", 0, 0, 0, v(0,0,0,0, 0,0,1,0,1,0, 0,0,0));

    // FENCE
    bus.inst_opcode = 7'b0001111;
    step("fence_f", 1, 0, 0, f1);
    step("fence_d", 0, 0, 0, z);
    step("fence_e", 0, 0, 0, v(0,0,0,0, 0,0,1,0,0,0, 0,0,0));

    // OP with inst_ready arriving on the 16th fetch cycle
    bus.inst_opcode = 7'b0110011;
    for (int i = 0; i < 15; i++) step("op_f_wait", 0, 0, 0, f0);
    step("op_f_ready16", 1, 0, 0, f1);
    step("op_d", 0, 0, 0, z);
    step("op_e", 0, 0, 0, z);
    step("op_wb", 0, 0, 0, v(0,0,0,0, 0,0,1,0,1,0, 0,0,0));

    // Fetch timeout
    for (int i = 0; i < 16; i++) step("fetch_to_wait", 0, 0, 0, f0);
    step("fetch_to_halt", 0, 0, 0, v(0,0,0,0, 0,0,0,0,0,0, 0,0,1));
    step("fetch_to_absorb", 1, 1, 1, v(0,0,0,0, 0,0,0,0,0,0, 0,0,1));
    step("fetch_to_absorb2", 1, 0, 0, v(0,0,0,0, 0,0,0,0,0,0, 0,0,1));

    // Reset during a stalled store
    do_reset("rst_after_bus_error");
    bus.inst_opcode = 7'b0100011;
    step("sws_f", 1, 0, 0, f1);
    step("sws_d", 0, 0, 0, z);
    step("sws_e", 0, 0, 0, v(0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    step("sws_m1", 0, 0, 0, v(0,0,0,1, 0,0,0,0,0,0, 0,0,0));
    step("sws_m2", 0, 0, 0, v(0,0,0,1, 0,0,0,0,0,0, 0,0,0));
    do_reset("rst_mid_store");

    // Illegal opcode
    bus.inst_opcode = 7'b1111111;
    step("ill_f", 1, 0, 0, f1);
    step("ill_d", 0, 0, 0, z);
    for (int i = 0; i < 4; i++) step("ill_halt", 1, 1, 1, v(0,0,0,0, 0,0,0,0,0,0, 0,1,0));
    do_reset("rst_after_illegal");

    // ECALL/EBREAK class halts
    bus.inst_opcode = 7'b1110011;
    step("sys_f", 1, 0, 0, f1);
    step("sys_d", 0, 0, 0, z);
    step("sys_e", 0, 0, 0, z);
    step("sys_halt", 1, 0, 0, v(0,0,0,0, 0,0,0,0,0,0, 1,0,0));
    do_reset("rst_after_system");

    // Load timeout in MEMORY
    bus.inst_opcode = 7'b0000011;
    step("ldto_f", 1, 0, 0, f1);
    step("ldto_d", 0, 0, 0, z);
    step("ldto_e", 0, 0, 0, v(0,0,0,0, 0,1,0,0,0,0, 0,0,0));
    for (int i = 0; i < 16; i++) step("ldto_m_wait", 0, 0, 0, v(0,0,1,0, 0,0,0,0,0,0, 0,0,0));
    step("ldto_halt", 0, 1, 0, v(0,0,0,0, 0,0,0,0,0,0, 0,0,1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: maximum number of bus-wait cycles per access before a bus error.
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port inst_opcode  in  7  bits [6:0] of the instruction register.
REQ-005 SHALL have port branch_taken  in  1  branch comparator result, valid in EXECUTE.
REQ-006 SHALL have port inst_ready  in  1  instruction bus completion.
REQ-007 SHALL have port data_ready  in  1  data bus completion.
REQ-008 SHALL have port inst_read_enable  out  1  instruction fetch request.
REQ-009 SHALL have port inst_reg_write  out  1  instruction register load strobe.
REQ-010 SHALL have port data_read_enable  out  1  load request.
REQ-011 SHALL have port data_write_enable  out  1  store request.
REQ-012 SHALL have port alu_a_select  out  2  0=rs1, 1=pc, 2=zero.
REQ-013 SHALL have port alu_b_select  out  1  0=rs2, 1=immediate.
REQ-014 SHALL have port pc_write_enable  out  1  PC update strobe.
REQ-015 SHALL have port pc_source  out  1  0=pc+4, 1=ALU result.
REQ-016 SHALL have port regfile_write_enable  out  1  rd write strobe.
REQ-017 SHALL have port writeback_select  out  2  0=ALU, 1=load data, 2=pc+4.
REQ-018 SHALL have port halted, illegal_inst, bus_error  out  1 each  sticky status flags.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT; all outputs Moore-decoded from state plus a class register latched in DECODE.
REQ-020 FETCH: inst_read_enable=1; on inst_ready, inst_reg_write=1 for that cycle and next state DECODE; otherwise remain.
REQ-021 DECODE: one cycle; latch class (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, MISC_MEM, SYSTEM); unrecognised opcode -> HALT with illegal_inst=1.
REQ-022 EXECUTE selects: OP a=rs1,b=rs2; OP_IMM/LOAD/STORE/JALR a=rs1,b=imm; AUIPC/JAL/BRANCH a=pc,b=imm; LUI a=zero,b=imm.
REQ-023 EXECUTE transitions: LOAD/STORE -> MEMORY; OP/OP_IMM/LUI/AUIPC/JAL/JALR -> WRITEBACK; SYSTEM -> HALT with halted=1.
REQ-024 EXECUTE for BRANCH: pc_write_enable=1, pc_source=branch_taken, next FETCH; for MISC_MEM: pc_write_enable=1, pc_source=0, next FETCH.
REQ-025 MEMORY: LOAD holds data_read_enable=1, STORE holds data_write_enable=1 until data_ready; on data_ready, LOAD -> WRITEBACK; STORE -> pc_write_enable=1, pc_source=0, next FETCH.
REQ-026 WRITEBACK: one cycle; regfile_write_enable=1, pc_write_enable=1; writeback_select=1 for LOAD, 2 for JAL/JALR, else 0; pc_source=1 for JAL/JALR, else 0; next FETCH.
REQ-027 Wait counter SHALL count consecutive FETCH/MEMORY cycles without ready, clear on ready or state change; reaching WAIT_LIMIT-1 without ready -> HALT with bus_error=1.
REQ-028 Ready arriving in the same cycle the counter hits its limit SHALL win (normal completion, no bus_error).
REQ-029 HALT SHALL be absorbing until reset; all enables and strobes 0; flags held.
REQ-030 At most one strobe among inst_reg_write, regfile_write_enable, and any pc_write_enable pulse SHALL occur per instruction phase; no strobe outside its stated state.
REQ-031 Latency, zero-wait bus: OP 4 cycles, LOAD 5, STORE 4, BRANCH 3.

Reset
REQ-032 Reset SHALL force state FETCH, class register and wait counter 0, all flags 0 asynchronously; all strobes 0 and selects 0 while reset is high.
REQ-033 Reset asserted mid-MEMORY SHALL drop data_read_enable/data_write_enable in the same cycle, with no writeback.
REQ-034 First fetch request SHALL appear in the first cycle after reset deassertion.

Structure
REQ-035 Opcode constants, state enum, class enum and select encodings SHALL live in the shared config package.
REQ-036 The wait counter SHALL be the sub-module bus_wait_counter (clear, count, limit-reached outputs).

Verification
REQ-037 ADDI x1,x0,5 (opcode 0010011), zero-wait -> states FETCH,DECODE,EXECUTE,WRITEBACK; alu_b_select=1; regfile_write_enable for 1 cycle; pc_source=0.
REQ-038 LW with data_ready delayed 3 cycles -> data_read_enable high 4 cycles; writeback_select=1; total 8 cycles.
REQ-039 BEQ, branch_taken=1 then 0 -> pc_write_enable in EXECUTE, pc_source=1 then 0; no regfile write.
REQ-040 opcode 1111111 -> HALT, illegal_inst=1, all strobes 0 indefinitely.
REQ-041 inst_ready never asserted, WAIT_LIMIT=16 -> bus_error=1 after 16 FETCH cycles; ready on the 16th cycle -> DECODE, no error.
REQ-042 Reset during a stalled STORE -> data_write_enable low the same cycle; FETCH resumes in the first cycle after deassertion.
